// File: rtl/dma_bus_responder.sv
// dma_bus_responder: system-side bus arbiter and wait-stated byte memory
// answering the DMAC hold/strobe protocol, with a host load/inspect port
// that is usable only while the bus is not granted.
module dma_bus_responder #(
  parameter int AW          = 8,
  parameter int HOLD_LAT    = 2,
  parameter int WAIT_STATES = 1
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          HLD,
  output logic          HLDA,
  input  logic          EOP,
  input  logic [15:0]   Addrbus,
  input  logic          MEMR,
  input  logic          MEMW,
  input  logic [7:0]    Data_out,
  output logic [7:0]    Data_in,
  output logic          RDY,
  input  logic          HOST_WE,
  input  logic          HOST_RE,
  input  logic [AW-1:0] HOST_ADDR,
  input  logic [7:0]    HOST_WDATA,
  output logic [7:0]    HOST_RDATA,
  output logic          ERR
);

  typedef enum logic [1:0] {ARB_IDLE, ARB_SYNC, ARB_GRANT, ARB_RELEASE} arb_state_t;
  typedef enum logic [1:0] {ACC_IDLE, ACC_WAIT, ACC_DONE} acc_state_t;

  localparam logic [3:0] HOLD_LAT_C = 4'(HOLD_LAT);
  localparam logic [3:0] WAIT_C     = 4'(WAIT_STATES);

  arb_state_t arb_state, arb_next;
  acc_state_t acc_state, acc_next;
  logic [3:0] lat_cnt, lat_next;
  logic [3:0] wait_cnt, wait_next;

  logic [7:0]    mem [0:(1<<AW)-1];
  logic [AW-1:0] mem_addr, addr_q, acc_addr;
  logic          memr_q, memw_q, acc_write;
  logic          strobe_rise, strobe_held, addr_change, start_evt, start;
  logic          host_wr, host_rd, err_set, unused_addr_bits;

  // Upper address bits only alias onto the memory, so they are folded away here.
  assign unused_addr_bits = ^(Addrbus >> AW);
  assign mem_addr         = Addrbus[AW-1:0];

  // Arbiter state and grant-latency counter.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      arb_state <= ARB_IDLE;
      lat_cnt   <= '0;
    end else begin
      arb_state <= arb_next;
      lat_cnt   <= lat_next;
    end
  end

  // Arbiter transitions: a dropped HLD always wins over EOP or a pending grant.
  always_comb begin
    arb_next = arb_state;
    lat_next = lat_cnt;
    case (arb_state)
      ARB_IDLE: begin
        if (HLD) begin
          arb_next = ARB_SYNC;
          lat_next = 4'd1;
        end
      end
      ARB_SYNC: begin
        if (!HLD)                     arb_next = ARB_IDLE;
        else if (lat_cnt == HOLD_LAT_C) arb_next = ARB_GRANT;
        else                          lat_next = lat_cnt + 4'd1;
      end
      ARB_GRANT: begin
        if (!HLD)     arb_next = ARB_IDLE;
        else if (EOP) arb_next = ARB_RELEASE;
      end
      ARB_RELEASE: begin
        if (!HLD) arb_next = ARB_IDLE;
      end
      default: arb_next = ARB_IDLE;
    endcase
  end

  // Grant acknowledge is decoded straight from the registered arbiter state.
  always_comb begin
    HLDA = (arb_state == ARB_GRANT);
  end

  // Previous strobe/address samples used to find access start events.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      memr_q <= 1'b0;
      memw_q <= 1'b0;
      addr_q <= '0;
    end else begin
      memr_q <= MEMR;
      memw_q <= MEMW;
      addr_q <= mem_addr;
    end
  end

  // A start is a strobe edge or an address step under a held strobe, granted bus only.
  always_comb begin
    strobe_rise = (MEMR && !memr_q) || (MEMW && !memw_q);
    strobe_held = (MEMR && memr_q) || (MEMW && memw_q);
    addr_change = strobe_held && (mem_addr != addr_q);
    start_evt   = (MEMR ^ MEMW) && (strobe_rise || addr_change) && (arb_state == ARB_GRANT);
    start       = start_evt && (acc_state == ACC_IDLE);
  end

  // Access state, wait counter and the latched address/direction.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      acc_state <= ACC_IDLE;
      wait_cnt  <= '0;
      acc_addr  <= '0;
      acc_write <= 1'b0;
    end else begin
      acc_state <= acc_next;
      wait_cnt  <= wait_next;
      if (start) begin
        acc_addr  <= mem_addr;
        acc_write <= MEMW;
      end
    end
  end

  // Access sequencing; an access in flight finishes even after the grant is gone.
  always_comb begin
    acc_next  = acc_state;
    wait_next = wait_cnt;
    case (acc_state)
      ACC_IDLE: begin
        if (start) begin
          acc_next  = (WAIT_STATES == 0) ? ACC_DONE : ACC_WAIT;
          wait_next = 4'd1;
        end
      end
      ACC_WAIT: begin
        if (wait_cnt == WAIT_C) acc_next = ACC_DONE;
        else                    wait_next = wait_cnt + 4'd1;
      end
      ACC_DONE: acc_next = ACC_IDLE;
      default:  acc_next = ACC_IDLE;
    endcase
  end

  // Ready is low only while wait states are being inserted.
  always_comb begin
    RDY = (acc_state != ACC_WAIT);
  end

  assign host_wr = HOST_WE && !HLDA;
  assign host_rd = HOST_RE && !HLDA;

  // Memory has no reset; bus writes commit in ACC_DONE, host writes only off-grant.
  always_ff @(posedge CLK) begin
    if (RST_N) begin
      if (host_wr)
        mem[HOST_ADDR] <= HOST_WDATA;
      if (acc_state == ACC_DONE && acc_write)
        mem[acc_addr] <= Data_out;
    end
  end

  // Read data registers; both hold their value until the next read.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      Data_in    <= 8'h00;
      HOST_RDATA <= 8'h00;
    end else begin
      if (acc_state == ACC_DONE && !acc_write)
        Data_in <= mem[acc_addr];
      if (host_rd)
        HOST_RDATA <= mem[HOST_ADDR];
    end
  end

  assign err_set = (MEMR && MEMW)
                || ((MEMR || MEMW) && (arb_state != ARB_GRANT))
                || (start_evt && (acc_state != ACC_IDLE))
                || ((HOST_WE || HOST_RE) && HLDA);

  // Sticky protocol-error flag, cleared only by reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)       ERR <= 1'b0;
    else if (err_set) ERR <= 1'b1;
  end

endmodule

// File: tb/tb_dma_bus_responder.sv
// tb_dma_bus_responder: randomized bench with a byte-array memory model and
// protocol timing derived from the grant latency and wait-state count.
module tb_dma_bus_responder;

  localparam int AW          = 8;
  localparam int HOLD_LAT    = 2;
  localparam int WAIT_STATES = 1;
  localparam int MEM_SIZE    = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          hld = 1'b0, eop = 1'b0, memr = 1'b0, memw = 1'b0;
  logic [15:0]   addrbus = '0;
  logic [7:0]    data_out = '0;
  logic          host_we = 1'b0, host_re = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [7:0]    host_wdata = '0;
  logic          hlda, rdy, err;
  logic [7:0]    data_in, host_rdata;

  int errors = 0;
  int checks = 0;
  logic [7:0] ref_mem [MEM_SIZE];
  logic [7:0] last_read = 8'h00;

  dma_bus_responder #(.AW(AW), .HOLD_LAT(HOLD_LAT), .WAIT_STATES(WAIT_STATES)) dut (
    .CLK(clk), .RST_N(rst_n), .HLD(hld), .HLDA(hlda), .EOP(eop),
    .Addrbus(addrbus), .MEMR(memr), .MEMW(memw), .Data_out(data_out),
    .Data_in(data_in), .RDY(rdy), .HOST_WE(host_we), .HOST_RE(host_re),
    .HOST_ADDR(host_addr), .HOST_WDATA(host_wdata), .HOST_RDATA(host_rdata),
    .ERR(err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hostWrite(input logic [AW-1:0] a, input logic [7:0] d);
    host_we = 1'b1; host_addr = a; host_wdata = d;
    tick();
    host_we = 1'b0;
    ref_mem[int'(a)] = d;
  endtask

  task automatic hostRead(input string tag, input logic [AW-1:0] a);
    host_re = 1'b1; host_addr = a;
    tick();
    host_re = 1'b0;
    checkOutput(tag, 16'(host_rdata), 16'(ref_mem[int'(a)]));
  endtask

  // HLD rises before edge k; HLDA must appear exactly HOLD_LAT edges later.
  task automatic requestGrant();
    hld = 1'b1;
    for (int j = 0; j <= HOLD_LAT; j++) begin
      tick();
      checkOutput("grant_latency", 16'(hlda), 16'(j == HOLD_LAT));
    end
  endtask

  task automatic releaseBus();
    hld = 1'b0;
    tick();
    checkOutput("release_hlda", 16'(hlda), 16'h0);
  endtask

  // One bus access; RDY low for WAIT_STATES edges, result visible after edge s+WAIT_STATES+1.
  task automatic busAccess(input bit is_write, input logic [15:0] a, input logic [7:0] d, input bit hold_strobe);
    int idx;
    idx = int'(a) % MEM_SIZE;
    addrbus = a; data_out = d;
    if (is_write) memw = 1'b1; else memr = 1'b1;
    for (int j = 0; j <= WAIT_STATES; j++) begin
      tick();
      checkOutput("rdy_wait", 16'(rdy), 16'(j >= WAIT_STATES));
    end
    tick();
    if (is_write) begin
      ref_mem[idx] = d;
      checkOutput("data_in_hold", 16'(data_in), 16'(last_read));
    end else begin
      last_read = ref_mem[idx];
      checkOutput("data_in", 16'(data_in), 16'(last_read));
    end
    if (!hold_strobe) begin
      memr = 1'b0; memw = 1'b0;
      tick();
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_hlda"}, 16'(hlda), 16'h0);
    checkOutput({tag, "_rdy"}, 16'(rdy), 16'h1);
    checkOutput({tag, "_data_in"}, 16'(data_in), 16'h0);
    checkOutput({tag, "_host_rdata"}, 16'(host_rdata), 16'h0);
    checkOutput({tag, "_err"}, 16'(err), 16'h0);
  endtask

  // Assert reset between edges, check outputs before any clock edge, then release.
  task automatic asyncReset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetValues(tag);
    memr = 1'b0; memw = 1'b0; hld = 1'b0; eop = 1'b0; host_we = 1'b0; host_re = 1'b0;
    last_read = 8'h00;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic applyStimulus();
    logic [15:0] a16, prev;
    logic [7:0]  d, old;
    logic [AW-1:0] ha;
    bit wr;

    tick(); tick();
    checkResetValues("reset");
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < MEM_SIZE; i++) hostWrite(AW'(i), 8'($urandom));
    hostWrite(8'hA4, 8'h11); hostWrite(8'hA5, 8'h22); hostWrite(8'hA6, 8'h33);
    for (int i = 0; i < 6; i++) hostRead("host_read", AW'($urandom));

    ha = AW'($urandom); d = 8'($urandom);
    host_we = 1'b1; host_re = 1'b1; host_addr = ha; host_wdata = d;
    tick();
    host_we = 1'b0; host_re = 1'b0;
    checkOutput("host_we_re_old", 16'(host_rdata), 16'(ref_mem[int'(ha)]));
    ref_mem[int'(ha)] = d;
    hostRead("host_we_re_new", ha);

    requestGrant();
    releaseBus();
    hld = 1'b1; tick(); hld = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("aborted_req", 16'(hlda), 16'h0);
    end

    requestGrant();
    busAccess(1'b0, 16'h00A4, 8'h00, 1'b1);
    checkOutput("burst_a4", 16'(data_in), 16'h11);
    busAccess(1'b0, 16'h00A5, 8'h00, 1'b1);
    checkOutput("burst_a5", 16'(data_in), 16'h22);
    busAccess(1'b0, 16'h00A6, 8'h00, 1'b1);
    checkOutput("burst_a6", 16'(data_in), 16'h33);
    prev = 16'h00A6;
    for (int i = 0; i < 6; i++) begin
      do a16 = 16'($urandom); while ((int'(a16) % MEM_SIZE) == (int'(prev) % MEM_SIZE));
      busAccess(1'b0, a16, 8'h00, i != 5);
      prev = a16;
    end

    for (int i = 0; i < 10; i++) begin
      wr = 1'($urandom);
      busAccess(wr, 16'($urandom), 8'($urandom), 1'b0);
    end
    busAccess(1'b1, 16'h0050, 8'h05, 1'b0);
    busAccess(1'b1, 16'h0151, 8'h0A, 1'b0);
    busAccess(1'b0, 16'h0350, 8'h00, 1'b0);
    checkOutput("alias_read", 16'(data_in), 16'h05);
    checkOutput("no_err_grant", 16'(err), 16'h0);
    releaseBus();
    hostRead("host_0x50", 8'h50);
    checkOutput("alias_0x50", 16'(host_rdata), 16'h05);
    hostRead("host_0x51", 8'h51);
    checkOutput("alias_0x51", 16'(host_rdata), 16'h0A);
    for (int i = 0; i < 6; i++) hostRead("host_after_bus", AW'($urandom));

    requestGrant();
    eop = 1'b1; tick(); eop = 1'b0;
    checkOutput("eop_drop", 16'(hlda), 16'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("eop_stay_low", 16'(hlda), 16'h0);
    end
    releaseBus();
    requestGrant();

    a16 = 16'($urandom); d = 8'($urandom);
    addrbus = a16; data_out = d; memw = 1'b1;
    tick();
    memw = 1'b0; eop = 1'b1;
    tick();
    eop = 1'b0;
    checkOutput("eop_mid_hlda", 16'(hlda), 16'h0);
    for (int j = 2; j <= WAIT_STATES + 1; j++) tick();
    ref_mem[int'(a16) % MEM_SIZE] = d;
    checkOutput("eop_mid_rdy", 16'(rdy), 16'h1);
    releaseBus();
    hostRead("eop_mid_write", AW'(a16));
    checkOutput("eop_mid_err", 16'(err), 16'h0);

    requestGrant();
    a16 = 16'($urandom);
    memr = 1'b1; memw = 1'b1; addrbus = a16;
    tick();
    memr = 1'b0; memw = 1'b0;
    checkOutput("both_strobes_err", 16'(err), 16'h1);
    for (int i = 0; i < 3; i++) tick();
    checkOutput("err_sticky", 16'(err), 16'h1);
    releaseBus();
    hostRead("both_strobes_mem", AW'(a16));

    requestGrant();
    a16 = 16'($urandom); old = ref_mem[int'(a16) % MEM_SIZE];
    addrbus = a16; data_out = ~old; memw = 1'b1;
    tick();
    asyncReset("reset_mid_access");
    hostRead("reset_dropped_write", AW'(a16));
    checkOutput("reset_dropped_value", 16'(host_rdata), 16'(old));
    for (int i = 0; i < 4; i++) hostRead("mem_intact", AW'($urandom));

    addrbus = 16'($urandom); memr = 1'b1;
    tick();
    memr = 1'b0;
    checkOutput("memr_no_grant_err", 16'(err), 16'h1);
    checkOutput("memr_no_grant_hlda", 16'(hlda), 16'h0);
    tick();
    asyncReset("reset_clear_err");

    requestGrant();
    ha = AW'($urandom);
    host_we = 1'b1; host_addr = ha; host_wdata = ~ref_mem[int'(ha)];
    tick();
    host_we = 1'b0;
    checkOutput("host_we_grant_err", 16'(err), 16'h1);
    releaseBus();
    hostRead("host_we_grant_mem", ha);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    applyStimulus();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
